hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Stall/flush sequencer for the 5-stage pipeline.
- Each cycle it compares the ID-stage source registers (rs, rt) against the destination registers held in ID/EX, EX/MEM and MEM/WB.
- On a read-after-write hazard it freezes PC and IF/ID, and injects bubbles into ID/EX for exactly the number of cycles needed for the producer to retire.
- A taken branch or jump from EX aborts any stall and squashes the younger instructions.

Parameters:
- RF_BYPASS, 1: 1 = register file writes in the first half-cycle and reads in the second (MEM/WB producer causes no stall); 0 = no write-through.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- ifid_valid  input  1  IF/ID holds a real instruction
- rs  input  3  ID-stage source register A
- rs_used  input  1  instruction reads rs
- rt  input  3  ID-stage source register B
- rt_used  input  1  instruction reads rt
- rdIDEX  input  3  destination register in ID/EX
- rdIDEXWrite  input  1  ID/EX instruction writes rdIDEX
- rdEXMEM  input  3  destination register in EX/MEM
- rdEXMEMWrite  input  1  EX/MEM instruction writes rdEXMEM
- rdMEMWB  input  3  destination register in MEM/WB
- rdMEMWBWrite  input  1  MEM/WB instruction writes rdMEMWB
- br_taken  input  1  EX-stage branch/jump redirect, one-cycle pulse
- pc_stall  output  1  hold PC
- ifid_stall  output  1  hold IF/ID register
- idex_bubble  output  1  load NOP into ID/EX
- ifid_flush  output  1  load NOP into IF/ID
- stall_active  output  1  registered: controller is in STALL
- stall_cycles  output  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- State machine: RUN, STALL. Internal down-counter `cnt` is 2 bits.
- Match terms:
  - match_X = X_Write & (rd_X == rs) & rs_used, OR X_Write & (rd_X == rt) & rt_used.
  - All terms are gated by ifid_valid.
- Required stall length N is the max over matching stages:
  - RF_BYPASS=1: IDEX→2, EXMEM→1, MEMWB→0.
  - RF_BYPASS=0: IDEX→3, EXMEM→2, MEMWB→1.
  - No match → N=0.
- RUN:
  - If br_taken: ifid_flush=1, idex_bubble=1, pc_stall=0, hazard ignored, stay RUN.
  - Else if N>0: pc_stall=ifid_stall=idex_bubble=1 in the same cycle (combinational).
    - If N>1: cnt<=N-1, go to STALL.
    - If N=1: stay RUN.
  - Else all control outputs 0.
- STALL:
  - Hazard comparators are ignored; the pipeline drains via the inserted bubbles.
  - pc_stall=ifid_stall=idex_bubble=1; cnt decrements each cycle; when cnt==1, next state is RUN.
  - br_taken in STALL: outputs become ifid_flush=1, idex_bubble=1, pc_stall=ifid_stall=0. Next state is RUN, cnt<=0.
- Total stall cycles for a hazard therefore equals N exactly.
- ifid_flush and ifid_stall are never both 1; flush has priority.
- stall_active is 1 exactly while the state is STALL.
- stall_cycles increments on each cycle with pc_stall=1 and saturates at all-ones (no wrap).
- Reset (synchronous, active-high):
  - State RUN, cnt=0, stall_cycles=0, stall_active=0.
  - While rst=1, pc_stall, ifid_stall, idex_bubble and ifid_flush are forced 0.
  - Reset asserted mid-STALL aborts the stall on the next edge.
- Register 0 is not special: a match on r0 stalls like any other register.
- Simultaneous matches in several stages: the largest N wins.
- rs==rt with both used counts as a single match.

Test Plan:
- RF_BYPASS=1, rs=3 used, rdIDEX=3 write=1 -> pc_stall/ifid_stall/idex_bubble high for exactly 2 cycles, stall_active high in the 2nd only; stall_cycles 0→2.
- RF_BYPASS=0, rt=5 used, rdEXMEM=5 write=1, rdMEMWB=5 write=1 -> stall 2 cycles (EXMEM wins). MEMWB-only match -> 1 cycle. With RF_BYPASS=1, MEMWB-only match -> 0 cycles.
- rs=2 matching rdIDEX=2 but rdIDEXWrite=0 or rs_used=0 or ifid_valid=0 -> no stall; outputs 0.
- RF_BYPASS=0, IDEX hazard, br_taken pulse in 2nd stall cycle -> that cycle ifid_flush=1, idex_bubble=1, pc_stall=0; next cycle RUN with all outputs 0 (no hazard presented).
- br_taken simultaneous with a new hazard in RUN -> flush only, no stall; stall_cycles unchanged.
- rst=1 in the 1st STALL cycle -> outputs 0 during reset, stall_active=0 and stall_cycles=0 after; counter preset near max (CNT_W=4, 14 stall cycles + 3) -> saturates at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Compares the ID-stage
// source registers against the destinations held in ID/EX, EX/MEM and
// MEM/WB. On a read-after-write hazard it freezes PC and IF/ID and injects
// bubbles into ID/EX until the producer has retired far enough. A taken
// branch/jump from EX aborts any stall and squashes the younger instructions.
//
// Parameters
//   RF_BYPASS : 1 = register file writes first half-cycle, reads second
//               (MEM/WB producer needs no stall); 0 = no write-through
//   CNT_W     : width of the saturating stall-cycle counter
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   ifid_valid        : IF/ID holds a real instruction
//   rs/rs_used        : ID source A and whether it is read
//   rt/rt_used        : ID source B and whether it is read
//   rdIDEX/..Write    : ID/EX destination and write enable
//   rdEXMEM/..Write   : EX/MEM destination and write enable
//   rdMEMWB/..Write   : MEM/WB destination and write enable
//   br_taken          : EX-stage redirect pulse
//   pc_stall          : hold PC
//   ifid_stall        : hold IF/ID
//   idex_bubble       : load NOP into ID/EX
//   ifid_flush        : load NOP into IF/ID
//   stall_active      : controller is in STALL (state register)
//   stall_cycles      : saturating count of cycles with pc_stall=1
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifid_valid,
  input  logic [2:0]       rs,
  input  logic             rs_used,
  input  logic [2:0]       rt,
  input  logic             rt_used,
  input  logic [2:0]       rdIDEX,
  input  logic             rdIDEXWrite,
  input  logic [2:0]       rdEXMEM,
  input  logic             rdEXMEMWrite,
  input  logic [2:0]       rdMEMWB,
  input  logic             rdMEMWBWrite,
  input  logic             br_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, STALL} state_t;

  // Cycles the consumer must wait for a producer in each stage. Write-through
  // in the register file removes one cycle from every distance.
  localparam logic [1:0] NEED_IDEX  = RF_BYPASS ? 2'd2 : 2'd3;
  localparam logic [1:0] NEED_EXMEM = RF_BYPASS ? 2'd1 : 2'd2;
  localparam logic [1:0] NEED_MEMWB = RF_BYPASS ? 2'd0 : 2'd1;

  state_t           r_state;
  state_t           w_stateNext;
  logic [1:0]       r_cnt;
  logic [1:0]       w_cntNext;
  logic [1:0]       w_need;
  logic             w_matchIdex;
  logic             w_matchExmem;
  logic             w_matchMemwb;
  logic [CNT_W-1:0] r_stallCycles;

  // A stage matches when it writes a register the ID instruction actually
  // reads. rs==rt with both used collapses naturally into one match.
  assign w_matchIdex  = ifid_valid & rdIDEXWrite &
                        (((rdIDEX == rs) & rs_used) | ((rdIDEX == rt) & rt_used));
  assign w_matchExmem = ifid_valid & rdEXMEMWrite &
                        (((rdEXMEM == rs) & rs_used) | ((rdEXMEM == rt) & rt_used));
  assign w_matchMemwb = ifid_valid & rdMEMWBWrite &
                        (((rdMEMWB == rs) & rs_used) | ((rdMEMWB == rt) & rt_used));

  // Required stall length is the maximum over matching stages. The stage
  // distances are monotone (IDEX > EXMEM > MEMWB), so checking from the
  // oldest producer to the youngest lets the later assignment win the max.
  always_comb begin
    w_need = 2'd0;
    if (w_matchMemwb) w_need = NEED_MEMWB;
    if (w_matchExmem) w_need = NEED_EXMEM;
    if (w_matchIdex)  w_need = NEED_IDEX;
  end

  // Next-state and control outputs. The first stall cycle is issued
  // combinationally from RUN, so STALL only covers the remaining N-1 cycles
  // and cnt holds how many of those are still to come. A redirect from EX
  // always wins: flush IF/ID, bubble ID/EX, let the PC take the new target.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (w_need != 2'd0) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            if (w_need > 2'd1) begin
              w_cntNext   = w_need - 2'd1;
              w_stateNext = STALL;
            end
          end
        end
        STALL: begin
          if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            w_cntNext   = 2'd0;
            w_stateNext = RUN;
          end else begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            w_cntNext   = r_cnt - 2'd1;
            if (r_cnt == 2'd1) w_stateNext = RUN;
          end
        end
        default: w_stateNext = RUN;
      endcase
    end
  end

  // State, down-counter and the saturating stall-cycle performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_cnt         <= 2'd0;
      r_stallCycles <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      if (pc_stall && (r_stallCycles != {CNT_W{1'b1}}))
        r_stallCycles <= r_stallCycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_active = (r_state == STALL);
  assign stall_cycles = r_stallCycles;

endmodule
